ball_position: RTL and testbench

- Integrates the per-frame X/Y motion words from the jump/motion controller into the ball's absolute screen position.
- Once per frame, captures the motion, adds it to the current position, clamps the result against the arena bounds, and commits it.
- Ball_X/Ball_Y feed back as the controller's BallX/BallY inputs and forward to the sprite renderer.
- Reports wall/ground/ceiling contact and missed frame ticks.

---
 rtl/ball_position_if.sv | 35 +++
 rtl/ball_position.sv | 182 ++++++++++++++++++
 tb/tb_ball_position.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_position_if.sv
// Bundles the ball_position per-frame inputs (pause, motion, arena bounds)
// and its committed position / status outputs into one port.
interface ball_position_if #(
    parameter int W = 21
);
    logic                Freeze;
    logic signed [W-1:0] Ball_X_Motion;
    logic signed [W-1:0] Ball_Y_Motion;
    logic signed [W-1:0] Ground_Y;
    logic signed [W-1:0] Ceiling_Y;
    logic signed [W-1:0] Left_X;
    logic signed [W-1:0] Right_X;
    logic signed [W-1:0] Ball_X;
    logic signed [W-1:0] Ball_Y;
    logic                Step_Done;
    logic                Hit_Ground;
    logic                Hit_Ceiling;
    logic                Hit_Left;
    logic                Hit_Right;
    logic                Overrun;

    modport master (
        output Freeze, Ball_X_Motion, Ball_Y_Motion,
               Ground_Y, Ceiling_Y, Left_X, Right_X,
        input  Ball_X, Ball_Y, Step_Done,
               Hit_Ground, Hit_Ceiling, Hit_Left, Hit_Right, Overrun
    );

    modport slave (
        input  Freeze, Ball_X_Motion, Ball_Y_Motion,
               Ground_Y, Ceiling_Y, Left_X, Right_X,
        output Ball_X, Ball_Y, Step_Done,
               Hit_Ground, Hit_Ceiling, Hit_Left, Hit_Right, Overrun
    );
endinterface

// File: rtl/ball_position.sv
// Ball position integrator: once per frame tick it samples the motion words
// and arena bounds, adds the motion to the current position, clamps against
// the arena and commits the result along with wall/ground/ceiling flags.
module ball_position #(
    parameter int W         = 21,
    parameter int BALL_SIZE = 32,
    parameter int INIT_X    = 320,
    parameter int INIT_Y    = 240
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_clk,
    ball_position_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        STEP,
        CLAMP,
        COMMIT
    } state_t;

    localparam logic signed [W-1:0] L_SIZE  = W'(BALL_SIZE);
    localparam logic signed [W-1:0] L_INITX = W'(INIT_X);
    localparam logic signed [W-1:0] L_INITY = W'(INIT_Y);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic [1:0]          r_armCnt;
    logic                w_armed;
    logic                w_tick;

    state_t              r_state;
    logic signed [W-1:0] r_mx;
    logic signed [W-1:0] r_my;
    logic signed [W-1:0] r_left;
    logic signed [W-1:0] r_right;
    logic signed [W-1:0] r_ceil;
    logic signed [W-1:0] r_ground;
    logic signed [W-1:0] r_nx;
    logic signed [W-1:0] r_ny;
    logic signed [W-1:0] r_ballX;
    logic signed [W-1:0] r_ballY;
    logic                r_stepDone;
    logic                r_hitGround;
    logic                r_hitCeiling;
    logic                r_hitLeft;
    logic                r_hitRight;
    logic                r_overrun;

    logic signed [W-1:0] w_nxRight;
    logic signed [W-1:0] w_clampX;
    logic signed [W-1:0] w_clampY;
    logic                w_hitGround;
    logic                w_hitCeiling;
    logic                w_hitLeft;
    logic                w_hitRight;

    // The edge detector stays disarmed until the chain holds two real samples,
    // so a frame_clk that is already high at reset release gives no tick.
    assign w_armed = (r_armCnt == 2'd3);
    assign w_tick  = w_armed & r_sync2 & ~r_prev;

    // Two-flop synchronizer for the vsync-derived strobe plus rising-edge history.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_armCnt <= 2'd0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_armCnt != 2'd3) begin
                r_armCnt <= r_armCnt + 2'd1;
            end
        end
    end

    // Clamp the stepped position: X checks left before right, Y checks ground before ceiling.
    always_comb begin
        w_nxRight    = r_nx + L_SIZE;
        w_clampX     = r_nx;
        w_clampY     = r_ny;
        w_hitLeft    = 1'b0;
        w_hitRight   = 1'b0;
        w_hitGround  = 1'b0;
        w_hitCeiling = 1'b0;
        if (r_nx < r_left) begin
            w_clampX  = r_left;
            w_hitLeft = 1'b1;
        end else if (w_nxRight > r_right) begin
            w_clampX   = r_right - L_SIZE;
            w_hitRight = 1'b1;
        end
        if (r_ny > r_ground) begin
            w_clampY    = r_ground;
            w_hitGround = 1'b1;
        end else if (r_ny < r_ceil) begin
            w_clampY     = r_ceil;
            w_hitCeiling = 1'b1;
        end
    end

    // Update sequencer: sample, step, clamp, commit; ticks that arrive mid-update are dropped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_mx         <= '0;
            r_my         <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_ceil       <= '0;
            r_ground     <= '0;
            r_nx         <= '0;
            r_ny         <= '0;
            r_ballX      <= L_INITX;
            r_ballY      <= L_INITY;
            r_stepDone   <= 1'b0;
            r_hitGround  <= 1'b0;
            r_hitCeiling <= 1'b0;
            r_hitLeft    <= 1'b0;
            r_hitRight   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_stepDone <= 1'b0;
            if (w_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_tick && !bus.Freeze) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_mx     <= bus.Ball_X_Motion;
                    r_my     <= bus.Ball_Y_Motion;
                    r_left   <= bus.Left_X;
                    r_right  <= bus.Right_X;
                    r_ceil   <= bus.Ceiling_Y;
                    r_ground <= bus.Ground_Y;
                    r_state  <= STEP;
                end
                STEP: begin
                    r_nx    <= r_ballX + r_mx;
                    r_ny    <= r_ballY + r_my;
                    r_state <= CLAMP;
                end
                CLAMP: begin
                    r_ballX      <= w_clampX;
                    r_ballY      <= w_clampY;
                    r_hitLeft    <= w_hitLeft;
                    r_hitRight   <= w_hitRight;
                    r_hitGround  <= w_hitGround;
                    r_hitCeiling <= w_hitCeiling;
                    r_stepDone   <= 1'b1;
                    r_state      <= COMMIT;
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Ball_X      = r_ballX;
    assign bus.Ball_Y      = r_ballY;
    assign bus.Step_Done   = r_stepDone;
    assign bus.Hit_Ground  = r_hitGround;
    assign bus.Hit_Ceiling = r_hitCeiling;
    assign bus.Hit_Left    = r_hitLeft;
    assign bus.Hit_Right   = r_hitRight;
    assign bus.Overrun     = r_overrun;

endmodule

// File: tb/tb_ball_position.sv
// Testbench for ball_position: table of per-frame vectors with hand-derived
// expected positions, a scoreboard queue, and multi-cycle corner sequences.
module tb_ball_position;

    localparam int W = 21;

    typedef struct {
        logic signed [W-1:0] mx;
        logic signed [W-1:0] my;
        logic signed [W-1:0] left;
        logic signed [W-1:0] right;
        logic signed [W-1:0] ceil;
        logic signed [W-1:0] ground;
        logic signed [W-1:0] expX;
        logic signed [W-1:0] expY;
        logic [3:0]          expHits;
    } vec_t;

    typedef struct {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic [3:0]          hits;
    } exp_t;

    logic Clk       = 1'b0;
    logic Reset_n   = 1'b0;
    logic frame_clk = 1'b0;

    ball_position_if #(.W(W)) bus ();

    ball_position #(
        .W(W),
        .BALL_SIZE(32),
        .INIT_X(320),
        .INIT_Y(240)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .frame_clk(frame_clk),
        .bus(bus)
    );

    exp_t expQ[$];
    vec_t vecs[11];
    int   testCount = 0;
    int   failCount = 0;
    int   stepCount = 0;

    // Free-running system clock.
    always #5 Clk = ~Clk;

    // Counts every commit pulse, sampled away from the active edge.
    always @(negedge Clk) begin
        if (bus.Step_Done) stepCount++;
    end

    function automatic vec_t mk(input int mx, input int my, input int l, input int r,
                                input int c, input int g, input int ex, input int ey,
                                input logic [3:0] h);
        vec_t v;
        v.mx = W'(mx);   v.my = W'(my);
        v.left = W'(l);  v.right = W'(r);
        v.ceil = W'(c);  v.ground = W'(g);
        v.expX = W'(ex); v.expY = W'(ey);
        v.expHits = h;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        testCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] hits();
        return {bus.Hit_Ground, bus.Hit_Ceiling, bus.Hit_Left, bus.Hit_Right};
    endfunction

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic loadInputs(input vec_t v);
        bus.Freeze        = 1'b0;
        bus.Ball_X_Motion = v.mx;
        bus.Ball_Y_Motion = v.my;
        bus.Left_X        = v.left;
        bus.Right_X       = v.right;
        bus.Ceiling_Y     = v.ceil;
        bus.Ground_Y      = v.ground;
    endtask

    task automatic pushExpected(input vec_t v);
        exp_t e;
        e.x = v.expX; e.y = v.expY; e.hits = v.expHits;
        expQ.push_back(e);
    endtask

    // Pops the scoreboard and compares the committed result and the pulse width.
    task automatic checkOutput(input string name, input int cycles, input int latency);
        exp_t e;
        check({name, " latency"}, cycles, latency);
        if (expQ.size() == 0) begin
            check({name, " scoreboard empty"}, 1, 0);
        end else begin
            e = expQ.pop_front();
            check({name, " Ball_X"}, int'(bus.Ball_X), int'(e.x));
            check({name, " Ball_Y"}, int'(bus.Ball_Y), int'(e.y));
            check({name, " hits"}, int'(hits()), int'(e.hits));
        end
        @(negedge Clk);
        check({name, " Step_Done pulse"}, int'(bus.Step_Done), 0);
    endtask

    // One frame: raise frame_clk, scramble inputs once they are sampled, wait for commit.
    task automatic applyStimulus(input vec_t v, input string name);
        int  cycles;
        bit  done;
        loadInputs(v);
        pushExpected(v);
        @(negedge Clk);
        frame_clk = 1'b1;
        cycles = 0;
        done = 0;
        while (!done && cycles < 20) begin
            @(posedge Clk);
            cycles++;
            @(negedge Clk);
            if (cycles == 2) frame_clk = 1'b0;
            if (cycles == 4) begin
                bus.Ball_X_Motion = W'($urandom);
                bus.Ball_Y_Motion = W'($urandom);
                bus.Left_X        = W'($urandom);
                bus.Right_X       = W'($urandom);
                bus.Ceiling_Y     = W'($urandom);
                bus.Ground_Y      = W'($urandom);
            end
            if (bus.Step_Done) done = 1;
        end
        checkOutput(name, cycles, 6);
        waitCycles(2);
    endtask

    initial begin
        int stepBefore;
        int cycles;
        bit done;

        vecs[0]  = mk(   2,  -16,    0, 640,   0, 479,  322,  224, 4'b0000);
        vecs[1]  = mk( 283,  246,    0, 640,   0, 479,  605,  470, 4'b0000);
        vecs[2]  = mk(   0,   15,    0, 640,   0, 479,  605,  479, 4'b1000);
        vecs[3]  = mk(   0,    0,    0, 640,   0, 479,  605,  479, 4'b0000);
        vecs[4]  = mk(   4,    0,    0, 640,   0, 479,  608,  479, 4'b0001);
        vecs[5]  = mk(-607,    0,    0, 640,   0, 479,    1,  479, 4'b0000);
        vecs[6]  = mk(  -2,    0,    0, 640,   0, 479,    0,  479, 4'b0010);
        vecs[7]  = mk(   0, -500,    0, 640,   0, 479,    0,    0, 4'b0100);
        vecs[8]  = mk( -50,    0, -100, 100, -50,  50,  -50,    0, 4'b0000);
        vecs[9]  = mk( 200,  100, -100, 100, -50,  50,   68,   50, 4'b1001);
        vecs[10] = mk(-500, -500, -100, 100, -50,  50, -100,  -50, 4'b0110);

        loadInputs(vecs[0]);

        // Reset with frame_clk held high across the release: no tick may result.
        frame_clk = 1'b1;
        waitCycles(3);
        Reset_n = 1'b1;
        waitCycles(12);
        check("reset Ball_X", int'(bus.Ball_X), 320);
        check("reset Ball_Y", int'(bus.Ball_Y), 240);
        check("reset hits", int'(hits()), 0);
        check("reset Overrun", int'(bus.Overrun), 0);
        check("reset no commit", stepCount, 0);
        frame_clk = 1'b0;
        waitCycles(4);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Freeze: three ticks are ignored with no overrun.
        stepBefore = stepCount;
        bus.Freeze = 1'b1;
        bus.Ball_X_Motion = W'(50);
        bus.Ball_Y_Motion = W'(50);
        for (int k = 0; k < 3; k++) begin
            frame_clk = 1'b1;
            waitCycles(2);
            frame_clk = 1'b0;
            waitCycles(4);
        end
        waitCycles(6);
        check("freeze no commit", stepCount - stepBefore, 0);
        check("freeze Ball_X", int'(bus.Ball_X), -100);
        check("freeze Ball_Y", int'(bus.Ball_Y), -50);
        check("freeze Overrun", int'(bus.Overrun), 0);

        // Two rises three cycles apart: first commits, second is dropped.
        stepBefore = stepCount;
        vecs[0] = mk(10, 10, -100, 100, -50, 50, -90, -40, 4'b0000);
        loadInputs(vecs[0]);
        pushExpected(vecs[0]);
        frame_clk = 1'b1;
        cycles = 0;
        done = 0;
        while (!done && cycles < 20) begin
            @(posedge Clk);
            cycles++;
            @(negedge Clk);
            if (cycles == 1) frame_clk = 1'b0;
            if (cycles == 3) frame_clk = 1'b1;
            if (cycles == 5) frame_clk = 1'b0;
            if (bus.Step_Done) done = 1;
        end
        checkOutput("overrun first", cycles, 6);
        waitCycles(12);
        check("overrun single commit", stepCount - stepBefore, 1);
        check("overrun flag", int'(bus.Overrun), 1);
        vecs[0] = mk(0, 0, -100, 100, -50, 50, -90, -40, 4'b0000);
        applyStimulus(vecs[0], "after overrun");
        check("overrun sticky", int'(bus.Overrun), 1);

        // Reset asserted while the update is in STEP: nothing commits.
        stepBefore = stepCount;
        vecs[0] = mk(7, 7, -100, 100, -50, 50, 0, 0, 4'b0000);
        loadInputs(vecs[0]);
        frame_clk = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (c == 2) frame_clk = 1'b0;
        end
        Reset_n = 1'b0;
        #1;
        check("midreset Ball_X", int'(bus.Ball_X), 320);
        check("midreset Ball_Y", int'(bus.Ball_Y), 240);
        check("midreset Overrun", int'(bus.Overrun), 0);
        check("midreset Step_Done", int'(bus.Step_Done), 0);
        waitCycles(3);
        Reset_n = 1'b1;
        waitCycles(12);
        check("midreset no commit", stepCount - stepBefore, 0);
        check("midreset hold X", int'(bus.Ball_X), 320);
        check("midreset hold Y", int'(bus.Ball_Y), 240);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
